// File: rtl/inv_fa_sample_ctrl.sv
// -----------------------------------------------------------------------------
// inv_fa_sample_ctrl
//
// Sequencing controller for a single invertible full-adder p-bit network
// (a, b, cin, s, cout). For every operation it:
//   1. captures the mode, the operand/clamp bits and the update-mode request,
//   2. holds the adder network in reset for one LOAD cycle with the clamps
//      already applied,
//   3. anneals the network by stepping I_0 from I0_START up to I0_END,
//   4. counts the ones seen on each p-bit over an N_SAMPLES-cycle window,
//   5. publishes the per-bit counts plus a strict-majority vote and pulses done.
//
// This block is the only driver of the adder's I_0, clamp, update_mode and
// reset inputs. Every output comes straight from a flop.
//
// Ports
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   start        in   single-cycle operation request, honoured only in IDLE
//   abort        in   return to IDLE from any busy state, no done pulse
//   mode         in   00 forward, 01 inverse, 10 subtract, 11 free-run
//   op_bits      in   clamp values {cout, s, cin, b, a}
//   upd_mode_in  in   update-sequencer mode request
//   p_bits       in   adder p-bit outputs {cout, s, cin, b, a}
//   fa_reset     out  reset to the adder network
//   I_0          out  inverse temperature to the adder
//   update_mode  out  update-sequencer mode, valid from LOAD through DONE
//   *_clamp      out  per-bit clamp control, bit1 = enable, bit0 = value
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse when counts/result are valid
//   counts       out  per-bit ones-counts {cout, s, cin, b, a}, a in the LSBs
//   result       out  majority vote per bit, same order as p_bits
// -----------------------------------------------------------------------------
module inv_fa_sample_ctrl #(
    parameter int unsigned N_SAMPLES      = 1024,
    parameter int unsigned CNT_W          = 16,
    parameter logic [3:0]  I0_START       = 4'd1,
    parameter logic [3:0]  I0_END         = 4'd8,
    parameter int unsigned I0_STEP_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [4:0]         op_bits,
    input  logic               upd_mode_in,
    input  logic [4:0]         p_bits,
    output logic               fa_reset,
    output logic [3:0]         I_0,
    output logic               update_mode,
    output logic [1:0]         a_clamp,
    output logic [1:0]         b_clamp,
    output logic [1:0]         cin_clamp,
    output logic [1:0]         s_clamp,
    output logic [1:0]         cout_clamp,
    output logic               busy,
    output logic               done,
    output logic [5*CNT_W-1:0] counts,
    output logic [4:0]         result
);

    // Bit positions inside op_bits / p_bits / counts / result.
    localparam int unsigned BIT_A    = 0;
    localparam int unsigned BIT_B    = 1;
    localparam int unsigned BIT_CIN  = 2;
    localparam int unsigned BIT_S    = 3;
    localparam int unsigned BIT_COUT = 4;

    // Step counter only needs to reach I0_STEP_CYCLES-1; keep it at least 1 bit
    // wide so the no-anneal configuration still elaborates cleanly.
    localparam int unsigned STEP_W = (I0_STEP_CYCLES > 1) ? $clog2(I0_STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST =
        STEP_W'((I0_STEP_CYCLES > 0) ? (I0_STEP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(N_SAMPLES - 1);
    // Majority threshold compared against 2*count, hence one extra bit.
    localparam logic [CNT_W:0]    MAJ_LIMIT   = (CNT_W + 1)'(N_SAMPLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ANNEAL,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_FWD  = 2'b00,
        MODE_INV  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_FREE = 2'b11
    } mode_e;

    typedef logic [4:0][1:0]       clamp_t;
    typedef logic [4:0][CNT_W-1:0] count_t;

    // Which bits are pinned for each mode; a pinned bit is driven {1, op_bit},
    // a free bit is left at 2'b00 so the network can settle it.
    function automatic clamp_t clamp_map(input logic [1:0] m, input logic [4:0] op);
        logic [4:0] en;
        clamp_t     cl;
        case (mode_e'(m))
            MODE_FWD:  en = (5'b1 << BIT_A) | (5'b1 << BIT_B) | (5'b1 << BIT_CIN);
            MODE_INV:  en = (5'b1 << BIT_S) | (5'b1 << BIT_COUT);
            MODE_SUB:  en = (5'b1 << BIT_A) | (5'b1 << BIT_S) | (5'b1 << BIT_CIN);
            MODE_FREE: en = 5'b00000;
            default:   en = 5'b00000;
        endcase
        for (int i = 0; i < 5; i++) begin
            cl[i] = en[i] ? {1'b1, op[i]} : 2'b00;
        end
        return cl;
    endfunction

    state_e            state_q;
    clamp_t            clamp_q;
    logic [3:0]        i0_q;
    logic              fa_reset_q;
    logic              update_mode_q;
    logic              busy_q;
    logic              done_q;
    count_t            counts_q;
    logic [4:0]        result_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  sample_q;

    count_t            counts_d;
    logic [4:0]        result_d;

    // Counts after the current sample edge and the vote they would produce.
    // The vote is only latched on the last sample edge, so it always sees the
    // complete window including that final sample.
    // NOTE: every always_comb output gets an assignment on every path; here the
    // loop covers all five bits unconditionally, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            counts_d[i] = counts_q[i] + CNT_W'(p_bits[i]);
            // Strict majority: 2*count > N_SAMPLES, so a tie votes 0.
            result_d[i] = ({counts_d[i], 1'b0} > MAJ_LIMIT);
        end
    end

    // Single-process FSM: state and every output flop are updated together so
    // the outputs line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of statement
    // order; later assignments in the same edge simply override earlier ones.
    // NOTE: the five counters are ordinary flops, not a memory, so clearing them
    // in reset is cheap and gives a defined counts output from power-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            clamp_q       <= '0;
            i0_q          <= '0;
            fa_reset_q    <= 1'b1;
            update_mode_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            counts_q      <= '0;
            result_q      <= '0;
            step_q        <= '0;
            sample_q      <= '0;
        end else if (abort && (state_q != ST_IDLE)) begin
            // Abort drops the operation on the spot: partial counts and the
            // previous result are left untouched, and no done is produced.
            state_q       <= ST_IDLE;
            clamp_q       <= '0;
            i0_q          <= '0;
            fa_reset_q    <= 1'b1;
            update_mode_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    // abort in IDLE has nothing to cancel but still swallows
                    // a coincident start.
                    if (start && !abort) begin
                        state_q       <= ST_LOAD;
                        clamp_q       <= clamp_map(mode, op_bits);
                        update_mode_q <= upd_mode_in;
                        i0_q          <= I0_START;
                        fa_reset_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        counts_q      <= '0;
                    end
                end

                ST_LOAD: begin
                    fa_reset_q <= 1'b0;
                    step_q     <= '0;
                    sample_q   <= '0;
                    if (I0_STEP_CYCLES == 0) begin
                        state_q <= ST_SAMPLE;
                        i0_q    <= I0_END;
                    end else begin
                        state_q <= ST_ANNEAL;
                    end
                end

                ST_ANNEAL: begin
                    // Each I_0 value, I0_END included, is held for exactly
                    // I0_STEP_CYCLES cycles before moving on.
                    if (step_q == STEP_LAST) begin
                        step_q <= '0;
                        if (i0_q == I0_END) begin
                            state_q <= ST_SAMPLE;
                        end else begin
                            i0_q <= i0_q + 4'd1;
                        end
                    end else begin
                        step_q <= step_q + STEP_W'(1);
                    end
                end

                ST_SAMPLE: begin
                    counts_q <= counts_d;
                    if (sample_q == SAMPLE_LAST) begin
                        state_q    <= ST_DONE;
                        result_q   <= result_d;
                        done_q     <= 1'b1;
                        i0_q       <= '0;
                        clamp_q    <= '0;
                        fa_reset_q <= 1'b1;
                    end else begin
                        sample_q <= sample_q + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    state_q       <= ST_IDLE;
                    busy_q        <= 1'b0;
                    update_mode_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fa_reset    = fa_reset_q;
    assign I_0         = i0_q;
    assign update_mode = update_mode_q;
    assign a_clamp     = clamp_q[BIT_A];
    assign b_clamp     = clamp_q[BIT_B];
    assign cin_clamp   = clamp_q[BIT_CIN];
    assign s_clamp     = clamp_q[BIT_S];
    assign cout_clamp  = clamp_q[BIT_COUT];
    assign busy        = busy_q;
    assign done        = done_q;
    assign counts      = counts_q;
    assign result      = result_q;

endmodule

// File: tb/tb_inv_fa_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inv_fa_sample_ctrl
//
// Directed bench for inv_fa_sample_ctrl. The adder network is replaced by
// p_bits patterns driven from the bench. Two instances are used:
//   dut_a: N_SAMPLES=16, I0_START=1, I0_END=3, I0_STEP_CYCLES=4
//          LOAD = cycle 1, ANNEAL = cycles 2..13, SAMPLE = cycles 14..29,
//          DONE = cycle 30, IDLE from cycle 31 (cycle k = k-th falling edge
//          after the rising edge that saw start).
//   dut_b: N_SAMPLES=4, CNT_W=8, I0_START=1, I0_END=3, I0_STEP_CYCLES=0
//          LOAD = cycle 1, SAMPLE = cycles 2..5, DONE = cycle 6.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_inv_fa_sample_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- dut_a ----------------
    logic        rst_a, start_a, abort_a, upd_a;
    logic [1:0]  mode_a;
    logic [4:0]  op_a, pb_a;
    logic        fa_reset_a, upd_o_a, busy_a, done_a;
    logic [3:0]  i0_a;
    logic [1:0]  ac_a, bc_a, cc_a, sc_a, oc_a;
    logic [79:0] counts_a;
    logic [4:0]  result_a;
    wire  [9:0]  clamps_a = {oc_a, sc_a, cc_a, bc_a, ac_a};

    inv_fa_sample_ctrl #(
        .N_SAMPLES(16), .CNT_W(16), .I0_START(4'd1), .I0_END(4'd3), .I0_STEP_CYCLES(4)
    ) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
        .mode(mode_a), .op_bits(op_a), .upd_mode_in(upd_a), .p_bits(pb_a),
        .fa_reset(fa_reset_a), .I_0(i0_a), .update_mode(upd_o_a),
        .a_clamp(ac_a), .b_clamp(bc_a), .cin_clamp(cc_a), .s_clamp(sc_a), .cout_clamp(oc_a),
        .busy(busy_a), .done(done_a), .counts(counts_a), .result(result_a)
    );

    // ---------------- dut_b ----------------
    logic        rst_b, start_b, abort_b, upd_b;
    logic [1:0]  mode_b;
    logic [4:0]  op_b, pb_b;
    logic        fa_reset_b, upd_o_b, busy_b, done_b;
    logic [3:0]  i0_b;
    logic [1:0]  ac_b, bc_b, cc_b, sc_b, oc_b;
    logic [39:0] counts_b;
    logic [4:0]  result_b;
    wire  [9:0]  clamps_b = {oc_b, sc_b, cc_b, bc_b, ac_b};

    inv_fa_sample_ctrl #(
        .N_SAMPLES(4), .CNT_W(8), .I0_START(4'd1), .I0_END(4'd3), .I0_STEP_CYCLES(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .abort(abort_b),
        .mode(mode_b), .op_bits(op_b), .upd_mode_in(upd_b), .p_bits(pb_b),
        .fa_reset(fa_reset_b), .I_0(i0_b), .update_mode(upd_o_b),
        .a_clamp(ac_b), .b_clamp(bc_b), .cin_clamp(cc_b), .s_clamp(sc_b), .cout_clamp(oc_b),
        .busy(busy_b), .done(done_b), .counts(counts_b), .result(result_b)
    );

    // Expected {done, I_0, fa_reset, busy} for dut_a at cycle c of an operation.
    function automatic logic [6:0] tl_a(input int c);
        if (c == 1)       return {1'b0, 4'd1, 1'b1, 1'b1};
        else if (c <= 13) return {1'b0, 4'(1 + (c - 2) / 4), 1'b0, 1'b1};
        else if (c <= 29) return {1'b0, 4'd3, 1'b0, 1'b1};
        else if (c == 30) return {1'b1, 4'd0, 1'b1, 1'b1};
        else              return {1'b0, 4'd0, 1'b1, 1'b0};
    endfunction

    // Expected {done, I_0, fa_reset, busy} for dut_b at cycle c.
    function automatic logic [6:0] tl_b(input int c);
        if (c == 1)      return {1'b0, 4'd1, 1'b1, 1'b1};
        else if (c <= 5) return {1'b0, 4'd3, 1'b0, 1'b1};
        else if (c == 6) return {1'b1, 4'd0, 1'b1, 1'b1};
        else             return {1'b0, 4'd0, 1'b1, 1'b0};
    endfunction

    // Drive a one-cycle start; returns at the falling edge of cycle 1 (LOAD).
    task automatic launch_a(input logic [1:0] m, input logic [4:0] op, input logic u);
        @(negedge clk);
        mode_a  = m;
        op_a    = op;
        upd_a   = u;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic launch_b(input logic [1:0] m, input logic [4:0] op, input logic u);
        @(negedge clk);
        mode_b  = m;
        op_b    = op;
        upd_b   = u;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; mode_a = 2'b00; op_a = '0; upd_a = 1'b0; pb_a = '0;
        rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; mode_b = 2'b00; op_b = '0; upd_b = 1'b0; pb_b = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a, result_a} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_a_outputs: got %h want %h",
                     {done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a, result_a},
                     {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0});
        end
        n_cmp++;
        if (counts_a !== 80'd0) begin
            n_err++;
            $display("FAIL reset_a_counts: got %h want 0", counts_a);
        end
        n_cmp++;
        if ({done_b, i0_b, fa_reset_b, busy_b, upd_o_b, clamps_b, result_b, counts_b} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0, 40'd0}) begin
            n_err++;
            $display("FAIL reset_b_outputs: got %h want %h",
                     {done_b, i0_b, fa_reset_b, busy_b, upd_o_b, clamps_b, result_b, counts_b},
                     {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0, 40'd0});
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy_a, fa_reset_a, i0_a} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h want %h", {busy_a, fa_reset_a, i0_a}, {1'b0, 1'b1, 4'd0});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_forward;
        logic [79:0] exp_c;
        exp_c = {16'd16, 16'd0, 16'd16, 16'd0, 16'd16};
        pb_a = 5'b10101;
        launch_a(2'b00, 5'b00011, 1'b1);
        for (int c = 1; c <= 31; c++) begin
            if (c > 1) @(negedge clk);
            pb_a = 5'b10101;
            n_cmp++;
            if ({done_a, i0_a, fa_reset_a, busy_a} !== tl_a(c)) begin
                n_err++;
                $display("FAIL fwd_timeline cycle %0d: got %h want %h", c, {done_a, i0_a, fa_reset_a, busy_a}, tl_a(c));
            end
            if (c == 1) begin
                n_cmp++;
                if (clamps_a !== 10'b00_00_10_11_11) begin
                    n_err++;
                    $display("FAIL fwd_clamps: got %b want %b", clamps_a, 10'b00_00_10_11_11);
                end
                n_cmp++;
                if (upd_o_a !== 1'b1) begin
                    n_err++;
                    $display("FAIL fwd_update_mode: got %b want 1", upd_o_a);
                end
            end
            if (c == 30) begin
                n_cmp++;
                if (counts_a !== exp_c) begin
                    n_err++;
                    $display("FAIL fwd_counts: got %h want %h", counts_a, exp_c);
                end
                n_cmp++;
                if (result_a !== 5'b10101) begin
                    n_err++;
                    $display("FAIL fwd_result: got %b want %b", result_a, 5'b10101);
                end
                n_cmp++;
                if (clamps_a !== 10'd0) begin
                    n_err++;
                    $display("FAIL fwd_done_clamps: got %b want 0", clamps_a);
                end
            end
            if (c == 31) begin
                n_cmp++;
                if ({counts_a, result_a, upd_o_a} !== {exp_c, 5'b10101, 1'b0}) begin
                    n_err++;
                    $display("FAIL fwd_hold_after_done: got %h want %h", {counts_a, result_a, upd_o_a}, {exp_c, 5'b10101, 1'b0});
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_inverse;
        logic [79:0] exp_c;
        int j;
        exp_c = {16'd0, 16'd16, 16'd0, 16'd12, 16'd4};
        pb_a = 5'b01010;
        launch_a(2'b01, 5'b01111, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            j = c - 14;
            pb_a = (j >= 12) ? 5'b01001 : 5'b01010;
            if (c == 1) begin
                n_cmp++;
                if (clamps_a !== 10'b10_11_00_00_00) begin
                    n_err++;
                    $display("FAIL inv_clamps: got %b want %b", clamps_a, 10'b10_11_00_00_00);
                end
                n_cmp++;
                if (upd_o_a !== 1'b0) begin
                    n_err++;
                    $display("FAIL inv_update_mode: got %b want 0", upd_o_a);
                end
            end
        end
        n_cmp++;
        if (done_a !== 1'b1) begin
            n_err++;
            $display("FAIL inv_done: got %b want 1", done_a);
        end
        n_cmp++;
        if (counts_a !== exp_c) begin
            n_err++;
            $display("FAIL inv_counts: got %h want %h", counts_a, exp_c);
        end
        n_cmp++;
        if (result_a !== 5'b01010) begin
            n_err++;
            $display("FAIL inv_result: got %b want %b", result_a, 5'b01010);
        end
        n_cmp++;
        if ($countones(result_a[2:0]) != 1) begin
            n_err++;
            $display("FAIL inv_popcount: got %0d want 1", $countones(result_a[2:0]));
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_subtract;
        logic [79:0] exp_c;
        int j;
        exp_c = {16'd16, 16'd0, 16'd16, 16'd5, 16'd16};
        pb_a = 5'b10101;
        launch_a(2'b10, 5'b10111, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            j = c - 14;
            pb_a = (j >= 11) ? 5'b10111 : 5'b10101;
            if (c == 1) begin
                n_cmp++;
                if (clamps_a !== 10'b00_10_11_00_11) begin
                    n_err++;
                    $display("FAIL sub_clamps: got %b want %b", clamps_a, 10'b00_10_11_00_11);
                end
                n_cmp++;
                if (counts_a !== 80'd0) begin
                    n_err++;
                    $display("FAIL sub_counts_cleared_in_load: got %h want 0", counts_a);
                end
            end
        end
        n_cmp++;
        if ({done_a, counts_a} !== {1'b1, exp_c}) begin
            n_err++;
            $display("FAIL sub_counts: got %h want %h", {done_a, counts_a}, {1'b1, exp_c});
        end
        n_cmp++;
        if ({result_a[4], result_a[1]} !== 2'b10) begin
            n_err++;
            $display("FAIL sub_cout_b: got %b want %b", {result_a[4], result_a[1]}, 2'b10);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_tie;
        logic [79:0] exp_c;
        int j;
        exp_c = {16'd0, 16'd16, 16'd7, 16'd9, 16'd8};
        pb_a = 5'b00000;
        launch_a(2'b11, 5'b11111, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge clk);
            j = c - 14;
            if (j >= 0 && j < 16) pb_a = {1'b0, 1'b1, (j < 7), (j < 9), j[0]};
            else                  pb_a = 5'b00000;
            if (c == 1) begin
                n_cmp++;
                if (clamps_a !== 10'd0) begin
                    n_err++;
                    $display("FAIL free_clamps: got %b want 0", clamps_a);
                end
            end
        end
        n_cmp++;
        if ({done_a, counts_a} !== {1'b1, exp_c}) begin
            n_err++;
            $display("FAIL tie_counts: got %h want %h", {done_a, counts_a}, {1'b1, exp_c});
        end
        n_cmp++;
        if (result_a !== 5'b01010) begin
            n_err++;
            $display("FAIL tie_result: got %b want %b", result_a, 5'b01010);
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort;
        logic [79:0] exp_c;
        int seen;
        exp_c = {16'd6, 16'd0, 16'd6, 16'd0, 16'd6};
        pb_a = 5'b10101;
        launch_a(2'b00, 5'b00011, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            pb_a = 5'b10101;
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        n_cmp++;
        if ({done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0}) begin
            n_err++;
            $display("FAIL abort_outputs: got %h want %h", {done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a},
                     {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0});
        end
        n_cmp++;
        if (counts_a !== exp_c) begin
            n_err++;
            $display("FAIL abort_partial_counts: got %h want %h", counts_a, exp_c);
        end
        n_cmp++;
        if (result_a !== 5'b01010) begin
            n_err++;
            $display("FAIL abort_result_kept: got %b want %b", result_a, 5'b01010);
        end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        // abort and start together in IDLE: start is dropped.
        mode_a = 2'b00; op_a = 5'b00011; start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        n_cmp++;
        if ({busy_a, clamps_a, i0_a} !== {1'b0, 10'd0, 4'd0}) begin
            n_err++;
            $display("FAIL abort_beats_start: got %h want %h", {busy_a, clamps_a, i0_a}, {1'b0, 10'd0, 4'd0});
        end
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_ignored;
        logic [79:0] exp_c;
        exp_c = {16'd16, 16'd0, 16'd16, 16'd0, 16'd16};
        pb_a = 5'b10101;
        launch_a(2'b00, 5'b00011, 1'b1);
        for (int c = 1; c <= 31; c++) begin
            if (c > 1) @(negedge clk);
            pb_a = 5'b10101;
            if (c == 6) begin
                start_a = 1'b1; mode_a = 2'b01; op_a = 5'b11111; upd_a = 1'b0;
            end
            if (c == 7) start_a = 1'b0;
            n_cmp++;
            if ({done_a, i0_a, fa_reset_a, busy_a} !== tl_a(c)) begin
                n_err++;
                $display("FAIL ignore_timeline cycle %0d: got %h want %h", c, {done_a, i0_a, fa_reset_a, busy_a}, tl_a(c));
            end
            if (c == 10) begin
                n_cmp++;
                if ({clamps_a, upd_o_a} !== {10'b00_00_10_11_11, 1'b1}) begin
                    n_err++;
                    $display("FAIL ignore_clamps: got %b want %b", {clamps_a, upd_o_a}, {10'b00_00_10_11_11, 1'b1});
                end
            end
            if (c == 30) begin
                n_cmp++;
                if ({counts_a, result_a} !== {exp_c, 5'b10101}) begin
                    n_err++;
                    $display("FAIL ignore_results: got %h want %h", {counts_a, result_a}, {exp_c, 5'b10101});
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_anneal;
        int j;
        pb_b = 5'b00000;
        launch_b(2'b00, 5'b00011, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            j = c - 2;
            if (j >= 0 && j < 4) pb_b = {1'b0, (j == 0), (j != 0), 1'b1, j[0]};
            else                 pb_b = 5'b00000;
            n_cmp++;
            if ({done_b, i0_b, fa_reset_b, busy_b} !== tl_b(c)) begin
                n_err++;
                $display("FAIL noanneal_timeline cycle %0d: got %h want %h", c, {done_b, i0_b, fa_reset_b, busy_b}, tl_b(c));
            end
            if (c == 6) begin
                n_cmp++;
                if ({counts_b, result_b} !== {8'd0, 8'd1, 8'd3, 8'd4, 8'd2, 5'b00110}) begin
                    n_err++;
                    $display("FAIL noanneal_results: got %h want %h", {counts_b, result_b},
                             {8'd0, 8'd1, 8'd3, 8'd4, 8'd2, 5'b00110});
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid;
        int seen;
        pb_a = 5'b10101;
        launch_a(2'b00, 5'b00011, 1'b1);
        for (int c = 2; c <= 8; c++) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a, result_a} !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0}) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h want %h", {done_a, i0_a, fa_reset_a, busy_a, upd_o_a, clamps_a, result_a},
                     {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0});
        end
        n_cmp++;
        if (counts_a !== 80'd0) begin
            n_err++;
            $display("FAIL midreset_counts: got %h want 0", counts_a);
        end
        rst_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_subtract();
        test_tie();
        test_abort();
        test_start_ignored();
        test_no_anneal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
